// File: rtl/truth_table_sweeper.sv
// Purpose: exhaustive stimulus engine; drives every N_IN-bit pattern to a DUT and checks dut_y against EXPECT.
// Latency: busy/stim=0 one edge after start; each vector held HOLD clocks; results update on the edge that ends a vector.
// Backpressure: none; the sweep free-runs until done, abort or reset. start is ignored while busy.
//
// Ports:
//   clk, rst_n        single clock, asynchronous active-low reset
//   start             begin a sweep (accepted in IDLE or DONE), clears all results
//   loop              sampled at each sweep end; 1 = wrap to pattern 0 and continue
//   abort             leave DRIVE/DONE for IDLE; partial results are kept
//   dut_y             DUT response to stim, compared on the last hold cycle
//   stim              pattern under test, MSB = first DUT input
//   busy / done       state flags (DRIVE / DONE)
//   pass              done with zero mismatches
//   err_count         mismatches since start (saturating)
//   pass_count        completed sweeps since start (saturating)
//   first_err_valid   a mismatch has been recorded since start
//   first_err_idx     pattern index of the first mismatch
module truth_table_sweeper #(
    parameter int                   N_IN   = 4,
    parameter int                   HOLD   = 10,
    parameter logic [(1<<N_IN)-1:0] EXPECT = '0,
    parameter int                   CW     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            loop,
    input  logic            abort,
    input  logic            dut_y,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CW-1:0]   err_count,
    output logic [CW-1:0]   pass_count,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_idx
);

    // Hold counter needs at least one bit even when HOLD=1 (it then stays at 0).
    localparam int              HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [N_IN-1:0] IDX_LAST  = '1;
    localparam logic [CW-1:0]   CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [N_IN-1:0]   idx_q;
    logic [HCW-1:0]    hold_q;
    logic [CW-1:0]     err_q;
    logic [CW-1:0]     pass_q;
    logic              fev_q;
    logic [N_IN-1:0]   fei_q;

    logic              clear;
    logic              sample;
    logic              sweep_end;
    logic              mismatch;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control strobes. abort outranks both start and the
    // sample point, so an aborted cycle never records a compare.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        sample  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    clear   = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    sample = 1'b1;
                    if ((idx_q == IDX_LAST) && !loop) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sweep_end = sample && (idx_q == IDX_LAST);
    assign mismatch  = sample && (dut_y != EXPECT[idx_q]);

    // ------------------------------------------------------------------
    // Pattern index, hold timer and result accumulators
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            hold_q <= '0;
            err_q  <= '0;
            pass_q <= '0;
            fev_q  <= 1'b0;
            fei_q  <= '0;
        end else if (clear) begin
            idx_q  <= '0;
            hold_q <= '0;
            err_q  <= '0;
            pass_q <= '0;
            fev_q  <= 1'b0;
            fei_q  <= '0;
        end else if ((state_q == S_DRIVE) && !abort) begin
            if (sample) begin
                hold_q <= '0;
                // At the sweep end idx either wraps (loop) or parks on the
                // last pattern so stim keeps showing it in DONE.
                if (idx_q != IDX_LAST) begin
                    idx_q <= idx_q + 1'b1;
                end else if (loop) begin
                    idx_q <= '0;
                end
                if (mismatch) begin
                    if (err_q != CNT_MAX) begin
                        err_q <= err_q + 1'b1;
                    end
                    if (!fev_q) begin
                        fev_q <= 1'b1;
                        fei_q <= idx_q;
                    end
                end
                if (sweep_end && (pass_q != CNT_MAX)) begin
                    pass_q <= pass_q + 1'b1;
                end
            end else begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stim            = idx_q;
    assign busy            = (state_q == S_DRIVE);
    assign done            = (state_q == S_DONE);
    assign pass            = done && (err_q == '0);
    assign err_count       = err_q;
    assign pass_count      = pass_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: N_IN=4, HOLD=10, EXPECT=AND truth table
    logic        start_a = 1'b0, loop_a = 1'b0, abort_a = 1'b0, dut_y_a;
    logic [3:0]  stim_a, fei_a;
    logic        busy_a, done_a, pass_a, fev_a;
    logic [15:0] err_a, pc_a;
    int          mode_a = 0; // 0 = AND, 1 = stuck 0, 2 = NAND

    always_comb begin
        case (mode_a)
            1:       dut_y_a = 1'b0;
            2:       dut_y_a = ~(&stim_a);
            default: dut_y_a = &stim_a;
        endcase
    end

    truth_table_sweeper #(.N_IN(4), .HOLD(10), .EXPECT(16'h8000), .CW(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .loop(loop_a), .abort(abort_a),
        .dut_y(dut_y_a), .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .pass_count(pc_a), .first_err_valid(fev_a), .first_err_idx(fei_a)
    );

    // Instance B: EXPECT all ones, DUT stuck at 0 (abort scenarios)
    logic        start_b = 1'b0, loop_b = 1'b0, abort_b = 1'b0;
    logic [3:0]  stim_b, fei_b;
    logic        busy_b, done_b, pass_b, fev_b;
    logic [15:0] err_b, pc_b;

    truth_table_sweeper #(.N_IN(4), .HOLD(10), .EXPECT(16'hFFFF), .CW(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .loop(loop_b), .abort(abort_b),
        .dut_y(1'b0), .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .pass_count(pc_b), .first_err_valid(fev_b), .first_err_idx(fei_b)
    );

    // Instance C: N_IN=2, HOLD=1, 2-input AND
    logic        start_c = 1'b0, loop_c = 1'b0, abort_c = 1'b0;
    logic [1:0]  stim_c, fei_c;
    logic        busy_c, done_c, pass_c, fev_c;
    logic [15:0] err_c, pc_c;

    truth_table_sweeper #(.N_IN(2), .HOLD(1), .EXPECT(4'b1000), .CW(16)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .loop(loop_c), .abort(abort_c),
        .dut_y(&stim_c), .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .pass_count(pc_c), .first_err_valid(fev_c), .first_err_idx(fei_c)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, ".busy"}, 32'(busy_a), 0);
        check({tag, ".done"}, 32'(done_a), 0);
        check({tag, ".pass"}, 32'(pass_a), 0);
        check({tag, ".stim"}, 32'(stim_a), 0);
        check({tag, ".err"},  32'(err_a),  0);
        check({tag, ".pc"},   32'(pc_a),   0);
        check({tag, ".fev"},  32'(fev_a),  0);
        check({tag, ".fei"},  32'(fei_a),  0);
    endtask

    initial begin
        // ---------------- reset ----------------
        tick(2);
        check_a_zero("reset");
        rst_n = 1'b1;
        tick(1);

        // ---------------- single sweep, AND DUT ----------------
        mode_a = 0;
        start_a = 1'b1; tick(1); start_a = 1'b0;          // now at T
        check("and.busy_T", 32'(busy_a), 1);
        check("and.stim_T", 32'(stim_a), 0);
        tick(9);
        check("and.stim_T9", 32'(stim_a), 0);
        tick(1);
        check("and.stim_T10", 32'(stim_a), 1);
        tick(5);
        check("and.stim_k1", 32'(stim_a), 1);
        for (int k = 2; k < 16; k++) begin
            tick(10);
            check($sformatf("and.stim_k%0d", k), 32'(stim_a), 32'(k));
        end
        tick(4);                                           // T+159
        check("and.done_T159", 32'(done_a), 0);
        check("and.busy_T159", 32'(busy_a), 1);
        tick(1);                                           // T+160
        check("and.done", 32'(done_a), 1);
        check("and.busy_off", 32'(busy_a), 0);
        check("and.err", 32'(err_a), 0);
        check("and.pass", 32'(pass_a), 1);
        check("and.fev", 32'(fev_a), 0);
        check("and.pc", 32'(pc_a), 1);
        check("and.stim_hold", 32'(stim_a), 15);
        tick(3);
        check("and.done_stays", 32'(done_a), 1);

        // ---------------- stuck-at-0 DUT ----------------
        mode_a = 1;
        start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(160);
        check("s0.done", 32'(done_a), 1);
        check("s0.err", 32'(err_a), 1);
        check("s0.fei", 32'(fei_a), 15);
        check("s0.fev", 32'(fev_a), 1);
        check("s0.pass", 32'(pass_a), 0);

        // ---------------- NAND DUT ----------------
        mode_a = 2;
        start_a = 1'b1; tick(1); start_a = 1'b0;
        check("nand.clr_err", 32'(err_a), 0);
        check("nand.clr_fev", 32'(fev_a), 0);
        check("nand.clr_fei", 32'(fei_a), 0);
        check("nand.clr_pc", 32'(pc_a), 0);
        tick(160);
        check("nand.done", 32'(done_a), 1);
        check("nand.err", 32'(err_a), 16);
        check("nand.fei", 32'(fei_a), 0);
        check("nand.fev", 32'(fev_a), 1);

        // ---------------- loop mode: three sweeps ----------------
        mode_a = 0;
        loop_a = 1'b1;
        start_a = 1'b1; tick(1); start_a = 1'b0;
        tick(159);
        check("loop.stim_end1", 32'(stim_a), 15);
        check("loop.pc0", 32'(pc_a), 0);
        tick(1);                                           // T+160
        check("loop.busy_nogap", 32'(busy_a), 1);
        check("loop.done_low", 32'(done_a), 0);
        check("loop.stim_wrap", 32'(stim_a), 0);
        check("loop.pc1", 32'(pc_a), 1);
        tick(160);                                         // T+320
        check("loop.pc2", 32'(pc_a), 2);
        check("loop.busy2", 32'(busy_a), 1);
        tick(1);
        loop_a = 1'b0;
        tick(158);                                         // T+479
        check("loop.busy_T479", 32'(busy_a), 1);
        tick(1);                                           // T+480
        check("loop.done", 32'(done_a), 1);
        check("loop.pc3", 32'(pc_a), 3);
        check("loop.err", 32'(err_a), 0);
        check("loop.pass", 32'(pass_a), 1);

        // abort in DONE returns to IDLE, keeps results
        abort_a = 1'b1; tick(1); abort_a = 1'b0;
        check("abdone.done", 32'(done_a), 0);
        check("abdone.busy", 32'(busy_a), 0);
        check("abdone.pc", 32'(pc_a), 3);
        check("abdone.stim", 32'(stim_a), 15);

        // ---------------- start ignored while busy, then async reset ----------------
        mode_a = 2;
        start_a = 1'b1; tick(1); start_a = 1'b0;          // T
        tick(33);
        start_a = 1'b1; tick(1); start_a = 1'b0;          // T+34
        check("busy_start.stim3", 32'(stim_a), 3);
        tick(6);                                           // T+40
        check("busy_start.stim4", 32'(stim_a), 4);
        tick(55);                                          // T+95
        check("prerst.stim", 32'(stim_a), 9);
        check("prerst.err", 32'(err_a), 9);
        check("prerst.fev", 32'(fev_a), 1);
        rst_n = 1'b0;
        #1;
        check_a_zero("async_rst");
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // ---------------- abort mid-hold at idx 5 ----------------
        start_b = 1'b1; tick(1); start_b = 1'b0;          // T
        tick(54);
        abort_b = 1'b1; tick(1); abort_b = 1'b0;          // T+55
        check("abort.busy", 32'(busy_b), 0);
        check("abort.done", 32'(done_b), 0);
        check("abort.err", 32'(err_b), 5);
        check("abort.fev", 32'(fev_b), 1);
        check("abort.fei", 32'(fei_b), 0);
        check("abort.stim", 32'(stim_b), 5);
        check("abort.pc", 32'(pc_b), 0);

        // start + abort together in IDLE: stay idle, no clear
        start_b = 1'b1; abort_b = 1'b1; tick(1); start_b = 1'b0; abort_b = 1'b0;
        check("stab.busy", 32'(busy_b), 0);
        check("stab.err", 32'(err_b), 5);
        check("stab.stim", 32'(stim_b), 5);

        // fresh start clears, then abort exactly on a sample cycle
        start_b = 1'b1; tick(1); start_b = 1'b0;          // T
        check("restart.err", 32'(err_b), 0);
        check("restart.fev", 32'(fev_b), 0);
        check("restart.stim", 32'(stim_b), 0);
        check("restart.busy", 32'(busy_b), 1);
        tick(59);                                          // last hold cycle of idx 5
        abort_b = 1'b1; tick(1); abort_b = 1'b0;
        check("abort_sample.err", 32'(err_b), 5);
        check("abort_sample.stim", 32'(stim_b), 5);
        check("abort_sample.busy", 32'(busy_b), 0);

        // ---------------- HOLD=1, N_IN=2 ----------------
        start_c = 1'b1; tick(1); start_c = 1'b0;          // T
        check("h1.stim0", 32'(stim_c), 0);
        check("h1.busy", 32'(busy_c), 1);
        tick(1);
        check("h1.stim1", 32'(stim_c), 1);
        tick(1);
        check("h1.stim2", 32'(stim_c), 2);
        tick(1);
        check("h1.stim3", 32'(stim_c), 3);
        check("h1.done_low", 32'(done_c), 0);
        tick(1);
        check("h1.done", 32'(done_c), 1);
        check("h1.busy_off", 32'(busy_c), 0);
        check("h1.err", 32'(err_c), 0);
        check("h1.pass", 32'(pass_c), 1);
        check("h1.pc", 32'(pc_c), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Self-checking exhaustive stimulus engine for small combinational blocks. It replaces hand-written vector lists that step every input combination at a fixed interval. It drives all 2^N_IN input patterns to a device under test in ascending order, holding each pattern for HOLD clocks. On the last hold cycle it compares the DUT output against a parameterised truth table and accumulates pass/fail results. It sits beside the DUT in the bench or FPGA wrapper, and the DUT's output feeds straight back into it.

## Interface
- N_IN, 4: number of DUT inputs; sweep length is 2^N_IN vectors (1..16).
- HOLD, 10: clocks each vector is held (≥1).
- EXPECT, {2^N_IN{1'b0}}: expected truth table; bit k is the expected DUT output for input pattern k.
- CW, 16: width of error and pass counters.

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; sampled only in IDLE or DONE.
- loop  in  1  sampled at each sweep end; 1 = wrap and continue.
- abort  in  1  stop sweep, return to IDLE.
- dut_y  in  1  DUT response to stim.
- stim  out  N_IN  pattern driven to the DUT, MSB = first DUT input (a).
- busy  out  1  high in DRIVE.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  CW  mismatches since last start, saturating.
- pass_count  out  CW  completed sweeps since last start, saturating.
- first_err_valid  out  1  a mismatch has been recorded since start.
- first_err_idx  out  N_IN  pattern index of first mismatch.

## Operation
- States: IDLE, DRIVE, DONE. Reset value: IDLE. All outputs reset to 0.
- IDLE/DONE with start=1: clear idx, hold_cnt, err_count, pass_count and first_err_*, then go to DRIVE. DONE without start stays in DONE.
- stim = idx register at all times. It holds its last value in DONE and after abort.
- DRIVE: hold_cnt increments each clock. When hold_cnt==HOLD-1, the sample event occurs:
  - compare dut_y with EXPECT[idx];
  - on mismatch, err_count+1 (saturate at 2^CW-1);
  - on the first mismatch only, latch first_err_idx=idx and set first_err_valid;
  - hold_cnt←0.
- Sample at idx<2^N_IN-1: idx+1.
- Sample at idx=2^N_IN-1 (sweep end): pass_count+1 (saturating). If loop=1, idx wraps to 0 and the state stays DRIVE. Otherwise go to DONE; idx stays at the max value.
- abort=1 in DRIVE: go to IDLE next clock. No compare is made that cycle, even at a sample point. Counters and first_err_* keep their partial values. done stays 0.
- abort has priority over sample. start while in DRIVE is ignored. abort in IDLE/DONE is ignored, except that abort in DONE clears done (goes to IDLE).
- start and abort together in IDLE/DONE: abort wins, giving IDLE with no clear.
- Asynchronous reset at any point returns the block to IDLE with all outputs 0.

## Timing
- start sampled high at edge T: busy=1 and stim=0 from T+1.
- Each vector is held for exactly HOLD clocks. Compare uses dut_y as sampled at the edge that ends the vector's last cycle. The DUT path from stim to dut_y must settle in less than one clock.
- Single sweep: done rises at T+1+2^N_IN·HOLD. busy falls in the same cycle.
- Loop mode: there are no gap cycles between sweeps. pass_count updates on the edge following each sweep end.
- err_count, first_err_* and pass_count update one edge after the sample event. Their values are stable once done=1.
- HOLD=1: a new vector every clock. Every DRIVE cycle is a sample cycle.

## Test plan
- N_IN=4, HOLD=10, EXPECT=16'h8000, DUT = 4-input AND -> done at start+161 clocks, err_count=0, pass=1, first_err_valid=0, stim steps 0..15 every 10 clocks.
- Same setup, DUT output stuck at 0 -> err_count=1, first_err_idx=15, pass=0.
- Same setup, DUT = 4-input NAND -> err_count=16, first_err_idx=0, first_err_valid=1.
- loop=1 for two sweeps, then loop=0, DUT correct -> pass_count=3, err_count=0, no idle gap between sweeps, done after 480 DRIVE clocks.
- abort at idx=5 mid-hold, DUT stuck 0 with EXPECT=16'hFFFF -> IDLE next clock, err_count=5, done=0. A following start clears all results.
- rst_n pulled low at idx=9 -> all outputs 0 immediately. start while busy ignored (idx sequence unaffected). HOLD=1, N_IN=2 sweep completes in 4 clocks.
